maxpool2d: RTL
==============

// Module: maxpool2d
// PURPOSE
// - 2x2 stride-2 max-pool stage placed directly downstream of dwconv. Consumes its conv_dout/vld/end stream.
// - Input is CHANNEL signed N-bit lanes per pixel, arriving in raster order (row-major).
// - Emits one pooled pixel per 2x2 window, also in raster order.
// - RELU=1 fuses the activation into this stage: negative results are clamped to 0.
// PARAMETERS
// - N        16  lane width, signed fixed point.
// - CHANNEL  3   lanes per pixel; lane c occupies bits [c*N +: N].
// - SIZE     6   input frame width and height. Must be even; elaboration $error otherwise.
// - RELU     1   1: output = max(pooled, 0). 0: output = pooled.
// PORTS
// - clk            in   1              clock, rising edge.
// - rst_n          in   1              asynchronous active-low reset.
// - ce             in   1              clock enable; all state advances only when ce=1.
// - input_vld      in   1              input beat valid. Accepted when ce & input_vld.
// - input_din      in   CHANNEL*N      one pixel, all channels.
// - input_end      in   1              high with the last beat of a frame. Checked only, not needed.
// - pool_dout      out  CHANNEL*N      pooled pixel.
// - pool_dout_vld  out  1              one-cycle strobe per pooled pixel.
// - pool_dout_end  out  1              high together with the last pooled pixel of a frame.
// BEHAVIOUR
// Reset
// - pool_dout=0, pool_dout_vld=0, pool_dout_end=0.
// - col and row counters are 0; the hold register is 0.
// - Line buffer contents are don't-care and are not reset.
// Flow control
// - No backpressure; every accepted beat is consumed.
// - Gaps of any length between beats are legal, including gaps inside a frame.
// - With ce=0, every register (outputs included) holds its value.
// Counters
// - col counts 0..SIZE-1 and advances on each accepted beat.
// - When col wraps, row advances 0..SIZE-1.
// - When row wraps, both return to 0, so back-to-back frames need no idle cycle.
// Datapath (per lane, signed compare)
// - Even col: hold <= din.
// - Odd col: h = max(hold, din).
//   - Even row: linebuf[col>>1] <= h. No output is produced.
//   - Odd row: p = max(linebuf[col>>1], h).
// - Output value: pool_dout <= RELU ? (p<0 ? 0 : p) : p.
// - pool_dout_vld <= 1 for exactly that one ce-cycle.
// - Ties return either operand; the value is identical either way.
// - Widths: no growth and no saturation; output lanes are N bits, the same as the input.
// Latency
// - 1 ce-cycle from the accepted odd-row/odd-col beat to pool_dout_vld.
// - Output rate: (SIZE/2)^2 strobes per frame.
// End marker
// - pool_dout_end=1 with the strobe at row=SIZE-1, col=SIZE-1; otherwise 0.
// - If input_end arrives on a beat other than the last, a simulation-only $error is raised.
// - A mismatched input_end has no effect on the datapath.
// Between strobes
// - pool_dout holds its last value; pool_dout_vld and pool_dout_end are 0.
// Reset mid-frame
// - Counters return to 0 and the partial window is discarded.
// - The next accepted beat is treated as pixel (0,0).
// - Stale line-buffer data is never read: an even row always rewrites it before an odd row reads it.
// STRUCTURE
// Shared nn package
// - Function smax(a,b) for a signed N-bit max.
// - Function relu(x).
// - Lane-slice macro LANE(bus,c) = bus[c*N +: N].
// Sub-module pool_linebuf
// - SIZE/2 entries x CHANNEL*N bits.
// - One synchronous write port and one asynchronous read port, both addressed by col>>1.
// - Register array; no RAM inference is required.
// Top level
// - Counters, hold register, CHANNEL generate-loop compare lanes, output registers.
// TESTING
// Test 1: single frame, increasing data
// - Stimulus: CHANNEL=3, SIZE=6, RELU=0; input lane c = 16*row + col + c for each pixel.
// - Required: 9 strobes; pooled(i,j) lane c = 16*(2i+1) + (2j+1) + c.
// - Required: pool_dout_end only on the 9th strobe.
// Test 2: negatives and ReLU
// - Stimulus: all pixels -5, except (1,1) = -2.
// - RELU=0 required: first output -2, all others -5.
// - RELU=1 required: all 9 outputs are 0.
// Test 3: gaps and ce
// - Stimulus: Test 1 data with random idle cycles between beats; ce held low for 3 cycles mid-frame.
// - Required: values identical to Test 1.
// - Required: each strobe arrives exactly 1 ce-cycle after its triggering beat.
// - Required: no strobe and no state change while ce=0.
// Test 4: back-to-back frames
// - Stimulus: two frames streamed with no idle cycle between them.
// - Required: 18 strobes; end asserted on strobes 9 and 18; frame 2 values are correct.
// Test 5: reset mid-frame
// - Stimulus: assert rst_n=0 after 10 beats, then stream a full fresh frame.
// - Required: outputs are 0 during reset; exactly 9 correct strobes follow.
// Test 6: signed extremes
// - Stimulus: lanes of 0x7FFF and 0x8000 placed in the same window.
// - Required: output 0x7FFF, which confirms the compare is signed, not unsigned.

Source files
------------

// File: rtl/maxpool2d_pkg.sv
// maxpool2d shared types and helpers.
// Signed max / relu on a wide lane, plus a lane-slice macro.
package maxpool2d_pkg;

  localparam int XW    = 64;
  localparam int DEF_W = 48;

  function automatic logic signed [XW-1:0] smax(
    input logic signed [XW-1:0] a,
    input logic signed [XW-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [XW-1:0] relu(
    input logic signed [XW-1:0] x
  );
    return x[XW-1] ? '0 : x;
  endfunction

endpackage

`ifndef LANE
`define LANE(bus, c) bus[(c)*N +: N]
`endif

// File: rtl/maxpool2d_if.sv
// Pixel stream in / pooled stream out.
// master: upstream+sink side, slave: the pooling stage.
interface maxpool2d_if
  import maxpool2d_pkg::*;
#(
  parameter int W = DEF_W
);
  logic         input_vld;
  logic [W-1:0] input_din;
  logic         input_end;
  logic [W-1:0] pool_dout;
  logic         pool_dout_vld;
  logic         pool_dout_end;

  modport master (
    output input_vld, input_din, input_end,
    input  pool_dout, pool_dout_vld, pool_dout_end
  );

  modport slave (
    input  input_vld, input_din, input_end,
    output pool_dout, pool_dout_vld, pool_dout_end
  );
endinterface

// File: rtl/maxpool2d_pool_linebuf.sv
// Half-row buffer of horizontal pair maxima.
// Ports: clk, we/addr/wdata sync write, rdata async read.
module pool_linebuf
  import maxpool2d_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = 3,
  parameter int AW    = 2
)(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/maxpool2d.sv
// 2x2 stride-2 signed max-pool with optional fused ReLU.
// Ports: clk, rst_n, ce, bus (slave: pixel in, pooled out).
module maxpool2d
  import maxpool2d_pkg::*;
#(
  parameter int N       = 16,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 6,
  parameter int RELU    = 1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  maxpool2d_if.slave bus
);
  localparam int W    = CHANNEL * N;
  localparam int CW   = $clog2(SIZE);
  localparam int HALF = SIZE / 2;
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

  if (SIZE % 2 != 0) begin : g_chk
    $error("maxpool2d: SIZE must be even");
  end

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [W-1:0]  hold;
  logic [W-1:0]  h;
  logic [W-1:0]  lb;
  logic [W-1:0]  p_out;
  logic          acc;
  logic          col_last;
  logic          row_last;
  logic          we;
  logic [AW-1:0] addr;

  assign acc      = ce & bus.input_vld;
  assign col_last = (col == CW'(SIZE - 1));
  assign row_last = (row == CW'(SIZE - 1));
  assign addr     = AW'(col >> 1);
  // even rows park the pair max; odd rows consume it
  assign we       = acc & col[0] & ~row[0];

  pool_linebuf #(
    .W     (W),
    .DEPTH (HALF),
    .AW    (AW)
  ) u_lb (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (h),
    .rdata (lb)
  );

  for (genvar c = 0; c < CHANNEL; c++) begin : g_lane
    logic signed [N-1:0] a_hold;
    logic signed [N-1:0] a_din;
    logic signed [N-1:0] a_lb;
    logic signed [N-1:0] a_h;
    logic signed [N-1:0] a_p;
    logic signed [N-1:0] a_o;

    assign a_hold = `LANE(hold, c);
    assign a_din  = `LANE(bus.input_din, c);
    assign a_lb   = `LANE(lb, c);
    assign a_h    = N'(smax(XW'(a_hold), XW'(a_din)));
    assign a_p    = N'(smax(XW'(a_lb), XW'(a_h)));
    assign a_o    = (RELU != 0) ? N'(relu(XW'(a_p)))
                                : a_p;

    assign `LANE(h, c)     = a_h;
    assign `LANE(p_out, c) = a_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col               <= '0;
      row               <= '0;
      hold              <= '0;
      bus.pool_dout     <= '0;
      bus.pool_dout_vld <= 1'b0;
      bus.pool_dout_end <= 1'b0;
    end else if (ce) begin
      bus.pool_dout_vld <= 1'b0;
      bus.pool_dout_end <= 1'b0;
      if (bus.input_vld) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) begin
          row <= row_last ? '0 : row + 1'b1;
        end
        if (!col[0]) begin
          hold <= bus.input_din;
        end else if (row[0]) begin
          bus.pool_dout     <= p_out;
          bus.pool_dout_vld <= 1'b1;
          bus.pool_dout_end <= row_last & col_last;
        end
      end
    end
  end

  a_end: assert property (
    @(posedge clk) disable iff (!rst_n)
    (acc && bus.input_end) |-> (row_last && col_last)
  ) else $error("maxpool2d: input_end off last beat");

endmodule
